// File: rtl/layer_out_serializer.sv
// Captures a layer's parallel neuron outputs in one edge and streams them one word per beat
// with ready/valid back-pressure. Optional running arg-max is enabled by LAYER_SER_ARGMAX_EN.
module layer_out_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16,
    parameter int IDX_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             i_valid,
    input  logic [NN*dataWidth-1:0]   i_data,
    input  logic                      o_ready,
    output logic                      o_valid,
    output logic [dataWidth-1:0]      o_data,
    output logic [IDX_W-1:0]          o_index,
    output logic                      o_last,
    output logic                      o_busy,
    output logic                      o_overrun,
`ifdef LAYER_SER_ARGMAX_EN
    output logic                      o_skew,
    output logic                      o_max_valid,
    output logic [IDX_W-1:0]          o_max_idx,
    output logic [dataWidth-1:0]      o_max_val
`else
    output logic                      o_skew
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]                     state;
    logic [IDX_W-1:0]               idx;
    logic [NN-1:0][dataWidth-1:0]   mem;
    logic [dataWidth-1:0]           beat;
    logic                           last_idx, xfer, xfer_last, capture, drop;

    always_comb begin
        beat = '0;
        for (int n = 0; n < NN; n++)
            if (idx == IDX_W'(n)) beat = mem[n];
    end

    assign last_idx  = (idx == IDX_W'(NN - 1));
    assign xfer      = (state == S_SEND) && o_ready;
    assign xfer_last = xfer && last_idx;
    // A new vector is accepted when idle or exactly on the last-beat transfer (no bubble).
    assign capture   = i_valid[0] && ((state == S_IDLE) || xfer_last);
    assign drop      = i_valid[0] && !capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            o_overrun <= 1'b0;
            o_skew    <= 1'b0;
        end else begin
            if (capture) begin
                state <= S_SEND;
                idx   <= '0;
            end else if (xfer_last) begin
                state <= S_IDLE;
                idx   <= '0;
            end else if (xfer) begin
                idx   <= idx + 1'b1;
            end
            if (drop)                          o_overrun <= 1'b1;
            if (capture && (i_valid != '1))    o_skew    <= 1'b1;
        end
    end

    // Packed layout of mem matches i_data: neuron n sits at [n*dataWidth +: dataWidth].
    always_ff @(posedge clk) begin
        if (capture) mem <= i_data;
    end

    assign o_valid = (state == S_SEND);
    assign o_busy  = o_valid;
    assign o_data  = o_valid ? beat : '0;
    assign o_index = idx;
    assign o_last  = o_valid && last_idx;

`ifdef LAYER_SER_ARGMAX_EN
    logic [dataWidth-1:0] run_max;
    logic [IDX_W-1:0]     run_idx;
    logic                 take;

    // Beat 0 seeds the maximum; strict compare keeps the lowest index on ties.
    assign take = (idx == '0) || ($signed(beat) > $signed(run_max));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_max     <= '0;
            run_idx     <= '0;
            o_max_valid <= 1'b0;
            o_max_idx   <= '0;
            o_max_val   <= '0;
        end else begin
            o_max_valid <= xfer_last;
            if (xfer && take) begin
                run_max <= beat;
                run_idx <= idx;
            end
            if (xfer_last) begin
                o_max_val <= take ? beat : run_max;
                o_max_idx <= take ? idx  : run_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Randomized + directed bench for layer_out_serializer (NN=4) against a queue-based reference model.
module tb_layer_out_serializer;

    localparam int NN = 4;
    localparam int DW = 16;
    localparam int IW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NN-1:0]  i_valid = '0;
    logic [NN*DW-1:0] i_data = '0;
    logic           o_ready = 1'b0;
    logic           o_valid, o_last, o_busy, o_overrun, o_skew;
    logic [DW-1:0]  o_data;
    logic [IW-1:0]  o_index;
`ifdef LAYER_SER_ARGMAX_EN
    logic           o_max_valid;
    logic [IW-1:0]  o_max_idx;
    logic [DW-1:0]  o_max_val;
`endif

    layer_out_serializer #(.NN(NN), .dataWidth(DW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .o_valid(o_valid), .o_data(o_data), .o_index(o_index), .o_last(o_last),
        .o_busy(o_busy), .o_overrun(o_overrun),
`ifdef LAYER_SER_ARGMAX_EN
        .o_skew(o_skew), .o_max_valid(o_max_valid), .o_max_idx(o_max_idx), .o_max_val(o_max_val)
`else
        .o_skew(o_skew)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: words still to be sent for the current vector, plus sticky flags.
    logic [DW-1:0] q[$];
    logic          m_over = 1'b0, m_skew = 1'b0, m_mv = 1'b0;
    logic [IW-1:0] m_midx = '0, pend_idx = '0;
    logic [DW-1:0] m_mval = '0, pend_val = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_over = 1'b0; m_skew = 1'b0; m_mv = 1'b0;
        m_midx = '0;   m_mval = '0;
    endtask

    task automatic check_outputs();
        chk("valid", 32'(o_valid), 32'(q.size() != 0));
        chk("busy",  32'(o_busy),  32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("data",  32'(o_data),  32'(q[0]));
            chk("index", 32'(o_index), 32'(NN - q.size()));
            chk("last",  32'(o_last),  32'(q.size() == 1));
        end
        chk("overrun", 32'(o_overrun), 32'(m_over));
        chk("skew",    32'(o_skew),    32'(m_skew));
`ifdef LAYER_SER_ARGMAX_EN
        chk("max_valid", 32'(o_max_valid), 32'(m_mv));
        chk("max_idx",   32'(o_max_idx),   32'(m_midx));
        chk("max_val",   32'(o_max_val),   32'(m_mval));
`endif
    endtask

    task automatic step(input logic [NN-1:0] iv, input logic [NN*DW-1:0] d, input logic rdy);
        logic [DW-1:0] w[NN];
        int best;
        @(negedge clk);
        i_valid = iv; i_data = d; o_ready = rdy;
        check_outputs();
        m_mv = 1'b0;
        if (q.size() != 0 && rdy) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_mv = 1'b1; m_midx = pend_idx; m_mval = pend_val;
            end
        end
        if (iv[0]) begin
            if (q.size() == 0) begin
                for (int n = 0; n < NN; n++) begin
                    w[n] = d[n*DW +: DW];
                    q.push_back(w[n]);
                end
                best = 0;
                for (int n = 1; n < NN; n++)
                    if ($signed(w[n]) > $signed(w[best])) best = n;
                pend_idx = IW'(best);
                pend_val = w[best];
                if (iv != '1) m_skew = 1'b1;
            end else begin
                m_over = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        if ($urandom_range(0, 1) == 1) return DW'($urandom);
        return DW'($urandom_range(0, 6)) - DW'(3);
    endfunction

    localparam logic [NN*DW-1:0] V1234 = 64'h0004_0003_0002_0001;
    localparam logic [NN*DW-1:0] V5678 = 64'h0008_0007_0006_0005;
    localparam logic [NN*DW-1:0] VMAX1 = 64'h0003_0007_0007_FFF0;
    localparam logic [NN*DW-1:0] VMAX2 = 64'hFFFE_FFF7_FFFE_FFFB;

    initial begin
        logic [NN*DW-1:0] rd;
        logic [NN-1:0]    riv;

        // Reset state
        #3;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_busy",  32'(o_busy),  0);
        chk("rst_data",  32'(o_data),  0);
        chk("rst_index", 32'(o_index), 0);
        chk("rst_last",  32'(o_last),  0);
        chk("rst_over",  32'(o_overrun), 0);
        chk("rst_skew",  32'(o_skew),  0);
        @(negedge clk); rst = 1'b1;

        // Plain stream with o_ready high
        step(4'hF, V1234, 1'b1);
        repeat (5) step('0, '0, 1'b1);

        // Stalls: ready pattern 1,0,0,1,...
        step(4'hF, V1234, 1'b1);
        for (int c = 0; c < 12; c++) step('0, '0, (c % 3) == 0);

        // Back-to-back capture on the last-beat transfer
        step(4'hF, V1234, 1'b1);
        repeat (3) step('0, '0, 1'b1);
        step(4'hF, V5678, 1'b1);
        repeat (5) step('0, '0, 1'b1);

        // Capture during beat 1 is dropped and flags overrun
        step(4'hF, V1234, 1'b1);
        step('0, '0, 1'b1);
        step(4'hF, V5678, 1'b1);
        repeat (4) step('0, '0, 1'b1);

        // Skewed valid still captures
        step(4'h7, V5678, 1'b1);
        repeat (5) step('0, '0, 1'b1);

        // Arg-max vectors (stream checks apply in both builds)
        step(4'hF, VMAX1, 1'b1);
        repeat (5) step('0, '0, 1'b1);
        step(4'hF, VMAX2, 1'b1);
        repeat (5) step('0, '0, 1'b1);

        // Asynchronous reset during beat 2
        step(4'hF, V1234, 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        i_valid = '0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 0);
        chk("arst_busy",  32'(o_busy),  0);
        chk("arst_index", 32'(o_index), 0);
        chk("arst_last",  32'(o_last),  0);
        chk("arst_over",  32'(o_overrun), 0);
        chk("arst_skew",  32'(o_skew),  0);
        model_reset();
        @(negedge clk); rst = 1'b1;
        step(4'hF, V5678, 1'b1);
        repeat (5) step('0, '0, 1'b1);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < NN; n++) rd[n*DW +: DW] = rnd_word();
            riv = '0;
            if ($urandom_range(0, 3) == 0) riv = ($urandom_range(0, 4) == 0) ? 4'h7 : 4'hF;
            else if ($urandom_range(0, 7) == 0) riv = 4'hE;
            step(riv, rd, $urandom_range(0, 3) != 0);
        end
        repeat (12) step('0, '0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
